// File: rtl/tbus_arbiter.sv
// rtl/tbus_arbiter.sv - two-port round-robin tbus arbiter with a single outstanding transaction
module tbus_arbiter #(
   parameter int ADDR_WIDTH   = 64,
   parameter int DATA_WIDTH   = 64,
   parameter int OPTYPE_WIDTH = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    p0_tbus_index_valid,
   output logic                    p0_tbus_index_ready,
   input  logic [ADDR_WIDTH-1:0]   p0_tbus_index,
   input  logic [DATA_WIDTH-1:0]   p0_tbus_write_data,
   input  logic [DATA_WIDTH-1:0]   p0_tbus_write_mask,
   input  logic [OPTYPE_WIDTH-1:0] p0_tbus_operation_type,
   output logic [DATA_WIDTH-1:0]   p0_tbus_read_data,
   output logic                    p0_tbus_operation_done,
   input  logic                    p0_flush,
   input  logic                    p1_tbus_index_valid,
   output logic                    p1_tbus_index_ready,
   input  logic [ADDR_WIDTH-1:0]   p1_tbus_index,
   input  logic [DATA_WIDTH-1:0]   p1_tbus_write_data,
   input  logic [DATA_WIDTH-1:0]   p1_tbus_write_mask,
   input  logic [OPTYPE_WIDTH-1:0] p1_tbus_operation_type,
   output logic [DATA_WIDTH-1:0]   p1_tbus_read_data,
   output logic                    p1_tbus_operation_done,
   output logic                    mem_tbus_index_valid,
   input  logic                    mem_tbus_index_ready,
   output logic [ADDR_WIDTH-1:0]   mem_tbus_index,
   output logic [DATA_WIDTH-1:0]   mem_tbus_write_data,
   output logic [DATA_WIDTH-1:0]   mem_tbus_write_mask,
   output logic [OPTYPE_WIDTH-1:0] mem_tbus_operation_type,
   input  logic [DATA_WIDTH-1:0]   mem_tbus_read_data,
   input  logic                    mem_tbus_operation_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   state_t                  state;
   logic                    owner;
   logic                    last_grant;
   logic                    drop;
   logic [ADDR_WIDTH-1:0]   index_q;
   logic [DATA_WIDTH-1:0]   write_data_q;
   logic [DATA_WIDTH-1:0]   write_mask_q;
   logic [OPTYPE_WIDTH-1:0] operation_type_q;

   logic       req0;
   logic       req1;
   logic [1:0] win;
   logic       owner_flush;
   logic       done_fwd;

   assign req0 = p0_tbus_index_valid & ~p0_flush;
   assign req1 = p1_tbus_index_valid;

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      win = 2'b00;
      if (state == IDLE) begin
         if (req0 && req1)
            win = last_grant ? 2'b01 : 2'b10;
         else
            win = {req1, req0};
      end
   end

   assign p0_tbus_index_ready = win[0];
   assign p1_tbus_index_ready = win[1];

   // A flush only concerns transactions owned by the load/store port.
   assign owner_flush = ~owner & p0_flush;

   assign mem_tbus_index_valid    = (state == ISSUE) & ~owner_flush;
   assign mem_tbus_index          = index_q;
   assign mem_tbus_write_data     = write_data_q;
   assign mem_tbus_write_mask     = write_mask_q;
   assign mem_tbus_operation_type = operation_type_q;

   assign done_fwd = (state == BUSY) & mem_tbus_operation_done & ~(drop | owner_flush);
   assign p0_tbus_operation_done = done_fwd & ~owner;
   assign p1_tbus_operation_done = done_fwd & owner;
   assign p0_tbus_read_data      = owner ? '0 : mem_tbus_read_data;
   assign p1_tbus_read_data      = owner ? mem_tbus_read_data : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         owner            <= 1'b0;
         last_grant       <= 1'b1;
         drop             <= 1'b0;
         index_q          <= '0;
         write_data_q     <= '0;
         write_mask_q     <= '0;
         operation_type_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|win) begin
                  owner      <= win[1];
                  last_grant <= win[1];
                  drop       <= 1'b0;
                  state      <= ISSUE;
                  if (win[1]) begin
                     index_q          <= p1_tbus_index;
                     write_data_q     <= p1_tbus_write_data;
                     write_mask_q     <= p1_tbus_write_mask;
                     operation_type_q <= p1_tbus_operation_type;
                  end else begin
                     index_q          <= p0_tbus_index;
                     write_data_q     <= p0_tbus_write_data;
                     write_mask_q     <= p0_tbus_write_mask;
                     operation_type_q <= p0_tbus_operation_type;
                  end
               end
            end
            ISSUE: begin
               // Flush beats ready so a cancelled request never reaches the slave.
               if (owner_flush)
                  state <= IDLE;
               else if (mem_tbus_index_ready)
                  state <= BUSY;
            end
            BUSY: begin
               if (owner_flush)
                  drop <= 1'b1;
               if (mem_tbus_operation_done)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
